// File: rtl/fetch_pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the next-PC generator and the fetch stage:
//   CPU-wide widths, active-low enable/disable levels, instruction size
//   derived constants, the PC generator state encoding and the request
//   payload struct handed to the fetch stage.
// -----------------------------------------------------------------------------
package fetch_pkg;

   // CPU configuration widths
   localparam int ADDR_WIDTH     = 32;
   localparam int INST_WIDTH     = 32;
   localparam int BYTE_BIT_WIDTH = 8;

   // Active-low signalling levels
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   // Instruction size in bytes and the number of PC bits that are always zero
   localparam int INST_BYTES = INST_WIDTH / BYTE_BIT_WIDTH;
   localparam int INST_OFS   = $clog2(INST_BYTES);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      STALL = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

   // Request payload as seen by the fetch stage
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic                  pred_taken_;
      logic [ADDR_WIDTH-1:0] pred_addr;
   } fetch_req_t;

   // Clear the byte-offset bits of an address so it lands on an instruction
   function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] a);
      return a & ~ADDR_WIDTH'(INST_BYTES - 1);
   endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen_if
//   Request channel from the next-PC generator to the instruction-fetch
//   stage. Active-low request/ready handshake: a request transfers in a
//   cycle where both if_req_ and if_ready_ are low.
//   Signals:
//     if_req_        request valid (active low)         master -> slave
//     if_ready_      fetch stage accepts (active low)   slave  -> master
//     if_pc          PC of the request                  master -> slave
//     if_pred_taken_ predicted taken (active low)       master -> slave
//     if_pred_addr   predicted next PC                  master -> slave
// -----------------------------------------------------------------------------
interface fetch_pc_gen_if #(
   parameter int ADDR = 32
);
   logic            if_req_;
   logic            if_ready_;
   logic [ADDR-1:0] if_pc;
   logic            if_pred_taken_;
   logic [ADDR-1:0] if_pred_addr;

   modport master (
      output if_req_,
      input  if_ready_,
      output if_pc,
      output if_pred_taken_,
      output if_pred_addr
   );

   modport slave (
      input  if_req_,
      output if_ready_,
      input  if_pc,
      input  if_pred_taken_,
      input  if_pred_addr
   );
endinterface

// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
//   Next-PC generator at the head of the front end. Holds the fetch PC,
//   presents it to the BTB, and issues one fetch request per cycle,
//   choosing between the BTB target, the sequential successor and a
//   commit-time redirect.
//   Ports:
//     clk          clock
//     reset_       asynchronous active-low reset
//     btb_pc       PC presented to the BTB lookup (current fetch PC)
//     btb_hit      BTB confident hit for btb_pc (same cycle)
//     btb_addr     BTB predicted target for btb_pc
//     flush_       active-low commit redirect, highest priority
//     flush_addr   redirect target
//     halt_        active-low fetch halt request
//     ifc          request channel to the fetch stage (master side)
// -----------------------------------------------------------------------------
module fetch_pc_gen
   import fetch_pkg::*;
#(
   parameter int              ADDR     = ADDR_WIDTH,
   parameter int              INST     = INST_WIDTH,
   parameter logic [ADDR-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   reset_,
   output logic [ADDR-1:0]        btb_pc,
   input  logic                   btb_hit,
   input  logic [ADDR-1:0]        btb_addr,
   input  logic                   flush_,
   input  logic [ADDR-1:0]        flush_addr,
   input  logic                   halt_,
   fetch_pc_gen_if.master         ifc
);

   localparam int              BYTES_PER_INST = INST / BYTE_BIT_WIDTH;
   localparam logic [ADDR-1:0] OFS_MASK       = ADDR'(BYTES_PER_INST - 1);

   // State
   fetch_state_t    state_reg,     state_next;
   logic [ADDR-1:0] pc_reg,        pc_next;
   logic            lat_taken_reg, lat_taken_next;
   logic [ADDR-1:0] lat_addr_reg,  lat_addr_next;

   // Datapath
   logic [ADDR-1:0] seq_next;
   logic [ADDR-1:0] btb_target;
   logic [ADDR-1:0] pred_next;
   logic [ADDR-1:0] flush_target;
   logic            accepted;
   logic            halting;
   logic            flushing;

   // Request outputs
   logic            req_out_;
   logic [ADDR-1:0] pc_out;
   logic            taken_out_;
   logic [ADDR-1:0] pred_out;

   // Sequential successor wraps silently at the top of the address space
   assign seq_next     = pc_reg + ADDR'(BYTES_PER_INST);
   assign btb_target   = btb_addr & ~OFS_MASK;
   assign pred_next    = btb_hit ? btb_target : seq_next;
   assign flush_target = flush_addr & ~OFS_MASK;

   assign accepted = (ifc.if_ready_ == ENABLE_);
   assign halting  = (halt_ == ENABLE_);
   assign flushing = (flush_ == ENABLE_);

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_reg     <= BOOT;
         pc_reg        <= RESET_PC;
         lat_taken_reg <= DISABLE_;
         lat_addr_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         lat_taken_reg <= lat_taken_next;
         lat_addr_reg  <= lat_addr_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      lat_taken_next = lat_taken_reg;
      lat_addr_next  = lat_addr_reg;
      req_out_       = DISABLE_;
      pc_out         = pc_reg;
      taken_out_     = DISABLE_;
      pred_out       = '0;

      case (state_reg)
         // One idle cycle after reset release so the BTB sees a stable PC
         BOOT: begin
            state_next = halting ? HALT : FETCH;
         end

         FETCH: begin
            req_out_   = ENABLE_;
            taken_out_ = btb_hit ? ENABLE_ : DISABLE_;
            pred_out   = pred_next;
            if (accepted) begin
               pc_next = pred_next;
            end
            if (halting) begin
               state_next = HALT;
            end else if (!accepted) begin
               // Freeze the prediction so the pending request stays stable
               // even if the BTB entry changes while we wait
               lat_taken_next = btb_hit ? ENABLE_ : DISABLE_;
               lat_addr_next  = pred_next;
               state_next     = STALL;
            end
         end

         STALL: begin
            req_out_   = ENABLE_;
            taken_out_ = lat_taken_reg;
            pred_out   = lat_addr_reg;
            if (accepted) begin
               pc_next = lat_addr_reg;
            end
            if (halting) begin
               state_next = HALT;
            end else if (accepted) begin
               state_next = FETCH;
            end
         end

         HALT: begin
            // Parked until a redirect arrives
         end

         default: begin
            state_next = BOOT;
         end
      endcase

      // A redirect kills whatever request this cycle would have shown and
      // overrides halt, accept and boot
      if (flushing) begin
         req_out_   = DISABLE_;
         pc_next    = flush_target;
         state_next = FETCH;
      end
   end

   assign btb_pc             = pc_reg;
   assign ifc.if_req_        = req_out_;
   assign ifc.if_pc          = pc_out;
   assign ifc.if_pred_taken_ = taken_out_;
   assign ifc.if_pred_addr   = pred_out;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_gen
//   Directed bench for fetch_pc_gen. Each step drives inputs after a rising
//   edge, queues the expected request, and checks it on the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_pc_gen;
   import fetch_pkg::*;

   typedef struct packed {
      logic       req_;
      logic       full;     // compare payload fields too
      fetch_req_t r;
   } exp_t;

   logic        clk;
   logic        reset_;
   logic [31:0] btb_pc;
   logic        btb_hit;
   logic [31:0] btb_addr;
   logic        flush_;
   logic [31:0] flush_addr;
   logic        halt_;

   fetch_pc_gen_if #(.ADDR(32)) fif ();

   fetch_pc_gen #(
      .ADDR     (32),
      .INST     (32),
      .RESET_PC (32'h0)
   ) dut (
      .clk        (clk),
      .reset_     (reset_),
      .btb_pc     (btb_pc),
      .btb_hit    (btb_hit),
      .btb_addr   (btb_addr),
      .flush_     (flush_),
      .flush_addr (flush_addr),
      .halt_      (halt_),
      .ifc        (fif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t  exp_q[$];
   string tag_q[$];
   int    n_cmp = 0;
   int    n_mis = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      assert (obs === want)
      else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   // Queue one expectation, check it on the falling edge, then advance
   // to just after the next rising edge.
   task automatic step(input string tag, input logic req_, input logic full,
                       input logic [31:0] pc, input logic tk_, input logic [31:0] pa);
      exp_t  e;
      exp_t  g;
      string t;
      e.req_            = req_;
      e.full            = full;
      e.r.pc            = pc;
      e.r.pred_taken_   = tk_;
      e.r.pred_addr     = pa;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      g = exp_q.pop_front();
      t = tag_q.pop_front();
      $display("step %-12s req_=%b pc=%h taken_=%b pred=%h btb_pc=%h",
               t, fif.if_req_, fif.if_pc, fif.if_pred_taken_, fif.if_pred_addr, btb_pc);
      chk({t, ".req_"}, 32'(fif.if_req_), 32'(g.req_));
      chk({t, ".btb_pc"}, btb_pc, g.r.pc);
      if (g.full) begin
         chk({t, ".pc"}, fif.if_pc, g.r.pc);
         chk({t, ".taken_"}, 32'(fif.if_pred_taken_), 32'(g.r.pred_taken_));
         chk({t, ".pred"}, fif.if_pred_addr, g.r.pred_addr);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_        = 1'b0;
      btb_hit       = 1'b0;
      btb_addr      = 32'h0;
      flush_        = 1'b1;
      flush_addr    = 32'h0;
      halt_         = 1'b1;
      fif.if_ready_ = 1'b0;
      @(posedge clk);
      #1;

      // Reset values and boot cycle
      step("reset", 1'b1, 1'b1, 32'h0, 1'b1, 32'h0);
      reset_ = 1'b1;
      step("boot", 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);

      // Sequential fetch at full throughput
      step("seq0", 1'b0, 1'b1, 32'h0, 1'b1, 32'h4);
      step("seq4", 1'b0, 1'b1, 32'h4, 1'b1, 32'h8);
      step("seq8", 1'b0, 1'b1, 32'h8, 1'b1, 32'hC);
      step("seqC", 1'b0, 1'b1, 32'hC, 1'b1, 32'h10);

      // BTB hit accepted; target low bits ignored
      btb_hit = 1'b1; btb_addr = 32'h83;
      step("hit10", 1'b0, 1'b1, 32'h10, 1'b0, 32'h80);
      btb_hit = 1'b0;
      step("tgt80", 1'b0, 1'b1, 32'h80, 1'b1, 32'h84);

      // Hmm: the step above was accepted, so PC is now 0x84. Redirect to 0x10.
      flush_ = 1'b0; flush_addr = 32'h10;
      step("fl10", 1'b1, 1'b0, 32'h84, 1'b1, 32'h0);
      flush_ = 1'b1;

      // Stalled taken request holds its payload while the BTB changes
      btb_hit = 1'b1; btb_addr = 32'h80; fif.if_ready_ = 1'b1;
      step("stl0", 1'b0, 1'b1, 32'h10, 1'b0, 32'h80);
      btb_hit = 1'b0;
      step("stl1", 1'b0, 1'b1, 32'h10, 1'b0, 32'h80);
      btb_addr = 32'h44;
      step("stl2", 1'b0, 1'b1, 32'h10, 1'b0, 32'h80);
      fif.if_ready_ = 1'b0;
      step("stlacc", 1'b0, 1'b1, 32'h10, 1'b0, 32'h80);

      // Arrive at 0x80 after the stall; redirect to 0x20
      flush_ = 1'b0; flush_addr = 32'h20;
      step("fl20", 1'b1, 1'b0, 32'h80, 1'b1, 32'h0);
      flush_ = 1'b1;
      fif.if_ready_ = 1'b1;
      step("req20", 1'b0, 1'b1, 32'h20, 1'b1, 32'h24);

      // Flush kills an unaccepted request; accept in that cycle is ignored
      flush_ = 1'b0; flush_addr = 32'h103; fif.if_ready_ = 1'b0;
      step("fl103", 1'b1, 1'b0, 32'h20, 1'b1, 32'h0);
      // Back-to-back flush: the second wins
      flush_addr = 32'h40;
      step("fl40", 1'b1, 1'b0, 32'h100, 1'b1, 32'h0);
      flush_ = 1'b1;

      // Stall at 0x40 then halt without accept
      fif.if_ready_ = 1'b1;
      step("req40", 1'b0, 1'b1, 32'h40, 1'b1, 32'h44);
      halt_ = 1'b0;
      step("halt40", 1'b0, 1'b1, 32'h40, 1'b1, 32'h44);
      halt_ = 1'b1; fif.if_ready_ = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step($sformatf("hold%0d", i), 1'b1, 1'b0, 32'h40, 1'b1, 32'h0);
      end
      flush_ = 1'b0; flush_addr = 32'h200;
      step("fl200", 1'b1, 1'b0, 32'h40, 1'b1, 32'h0);
      flush_ = 1'b1;

      // Halt with accept in the same cycle: PC still advances
      halt_ = 1'b0;
      step("hacc200", 1'b0, 1'b1, 32'h200, 1'b1, 32'h204);
      halt_ = 1'b1;
      step("halted", 1'b1, 1'b0, 32'h204, 1'b1, 32'h0);

      // Flush together with halt: flush wins and fetch resumes at the top
      halt_ = 1'b0; flush_ = 1'b0; flush_addr = 32'hFFFF_FFFC;
      step("flhalt", 1'b1, 1'b0, 32'h204, 1'b1, 32'h0);
      halt_ = 1'b1; flush_ = 1'b1;
      step("top", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
      btb_hit = 1'b1; btb_addr = 32'h300;
      step("wrap0", 1'b0, 1'b1, 32'h0, 1'b0, 32'h300);
      btb_hit = 1'b0; fif.if_ready_ = 1'b1;
      step("stl300", 1'b0, 1'b1, 32'h300, 1'b1, 32'h304);

      // Reset mid-stall, then halt during the boot cycle
      reset_ = 1'b0;
      step("rst2", 1'b1, 1'b1, 32'h0, 1'b1, 32'h0);
      reset_ = 1'b1; halt_ = 1'b0; fif.if_ready_ = 1'b0;
      step("boot2", 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
      halt_ = 1'b1;
      step("bhalt", 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
      step("bhalt2", 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
